bridge_1x3: RTL and testbench

- Data-side request router, the fan-out counterpart of the 3:1 select muxes in the datapath.
- Takes one CPU sram-like data request stream and routes each transaction to one of three slaves by address decode: s0 = default RAM, s1 = config registers, s2 = boot ROM.
- Tracks the single outstanding transaction and returns the owning slave's response to the CPU.
- Includes a response watchdog so a dead slave cannot hang the pipeline.

---
 rtl/bridge_1x3.sv | 142 ++++++++++++++
 tb/tb_bridge_1x3.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_1x3.sv
// rtl/bridge_1x3.sv - 1:3 sram-like data request router with single-outstanding tracking and response watchdog
module bridge_1x3 #(
  parameter logic [31:0] S1_BASE  = 32'h1FAF_0000,
  parameter logic [31:0] S1_MASK  = 32'hFFFF_0000,
  parameter logic [31:0] S2_BASE  = 32'h1FC0_0000,
  parameter logic [31:0] S2_MASK  = 32'hFFF0_0000,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        s0_req,
  output logic        s0_wr,
  output logic [1:0]  s0_size,
  output logic [31:0] s0_addr,
  output logic [31:0] s0_wdata,
  input  logic        s0_addr_ok,
  input  logic        s0_data_ok,
  input  logic [31:0] s0_rdata,
  output logic        s1_req,
  output logic        s1_wr,
  output logic [1:0]  s1_size,
  output logic [31:0] s1_addr,
  output logic [31:0] s1_wdata,
  input  logic        s1_addr_ok,
  input  logic        s1_data_ok,
  input  logic [31:0] s1_rdata,
  output logic        s2_req,
  output logic        s2_wr,
  output logic [1:0]  s2_size,
  output logic [31:0] s2_addr,
  output logic [31:0] s2_wdata,
  input  logic        s2_addr_ok,
  input  logic        s2_data_ok,
  input  logic [31:0] s2_rdata
);

  localparam int unsigned WD_BITS = $clog2(TIMEOUT + 1);
  localparam int WDW = (WD_BITS > 8) ? WD_BITS : 8;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t         state_q, state_d;
  logic [1:0]     sel_q, sel_d, sel;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           sel_addr_ok, resp_ok, timeout_hit;
  logic [31:0]    resp_rdata;

  assign {s0_wr, s1_wr, s2_wr}          = {3{cpu_wr}};
  assign {s0_size, s1_size, s2_size}    = {3{cpu_size}};
  assign {s0_addr, s1_addr, s2_addr}    = {3{cpu_addr}};
  assign {s0_wdata, s1_wdata, s2_wdata} = {3{cpu_wdata}};

  // Boot ROM window wins over the config window if they ever overlap.
  always_comb begin
    sel = 2'd0;
    if ((cpu_addr & S2_MASK) == S2_BASE)      sel = 2'd2;
    else if ((cpu_addr & S1_MASK) == S1_BASE) sel = 2'd1;
  end

  always_comb begin
    sel_addr_ok = s0_addr_ok;
    case (sel)
      2'd1:    sel_addr_ok = s1_addr_ok;
      2'd2:    sel_addr_ok = s2_addr_ok;
      default: sel_addr_ok = s0_addr_ok;
    endcase
    resp_ok    = s0_data_ok;
    resp_rdata = s0_rdata;
    case (sel_q)
      2'd1: begin resp_ok = s1_data_ok; resp_rdata = s1_rdata; end
      2'd2: begin resp_ok = s2_data_ok; resp_rdata = s2_rdata; end
      default: begin resp_ok = s0_data_ok; resp_rdata = s0_rdata; end
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (wdog_q == WDW'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    wdog_d      = wdog_q;
    s0_req      = 1'b0;
    s1_req      = 1'b0;
    s2_req      = 1'b0;
    cpu_addr_ok = 1'b0;
    cpu_data_ok = 1'b0;
    cpu_rdata   = 32'h0;
    cpu_err     = 1'b0;
    case (state_q)
      IDLE: begin
        s0_req      = cpu_req & (sel == 2'd0);
        s1_req      = cpu_req & (sel == 2'd1);
        s2_req      = cpu_req & (sel == 2'd2);
        cpu_addr_ok = cpu_req & sel_addr_ok;
        if (cpu_addr_ok) begin
          sel_d   = sel;
          wdog_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The forced error wins even if the owner answers on that very cycle.
        if (timeout_hit) begin
          cpu_data_ok = 1'b1;
          cpu_rdata   = ERR_DATA;
          cpu_err     = 1'b1;
          state_d     = IDLE;
        end else if (resp_ok) begin
          cpu_data_ok = 1'b1;
          cpu_rdata   = resp_rdata;
          state_d     = IDLE;
        end else if (TIMEOUT != 0) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_bridge_1x3.sv
// tb/tb_bridge_1x3.sv - randomized and directed bench for bridge_1x3 against a transaction-level model
module tb_bridge_1x3;
  localparam logic [31:0] S1_BASE = 32'h1FAF_0000, S1_MASK = 32'hFFFF_0000;
  localparam logic [31:0] S2_BASE = 32'h1FC0_0000, S2_MASK = 32'hFFF0_0000;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic cpu_req, cpu_wr;
  logic [1:0] cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0] sao, sdo;
  logic [31:0] srd [3];
  wire cpu_addr_ok, cpu_data_ok, cpu_err;
  wire [31:0] cpu_rdata;
  wire s0_req, s1_req, s2_req, s0_wr, s1_wr, s2_wr;
  wire [1:0] s0_size, s1_size, s2_size;
  wire [31:0] s0_addr, s1_addr, s2_addr, s0_wdata, s1_wdata, s2_wdata;

  int total = 0;
  int bad = 0;

  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_age = 0;
  logic [37:0] m_now;

  always #5 clk = ~clk;

  bridge_1x3 #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .s0_req(s0_req), .s0_wr(s0_wr), .s0_size(s0_size), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s0_addr_ok(sao[0]), .s0_data_ok(sdo[0]), .s0_rdata(srd[0]),
    .s1_req(s1_req), .s1_wr(s1_wr), .s1_size(s1_size), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .s1_addr_ok(sao[1]), .s1_data_ok(sdo[1]), .s1_rdata(srd[1]),
    .s2_req(s2_req), .s2_wr(s2_wr), .s2_size(s2_size), .s2_addr(s2_addr), .s2_wdata(s2_wdata),
    .s2_addr_ok(sao[2]), .s2_data_ok(sdo[2]), .s2_rdata(srd[2])
  );

  wire [37:0] obs = {cpu_addr_ok, cpu_data_ok, cpu_err, s2_req, s1_req, s0_req, cpu_rdata};

  function automatic int decode(input logic [31:0] a);
    if ((a & S2_MASK) == S2_BASE) return 2;
    if ((a & S1_MASK) == S1_BASE) return 1;
    return 0;
  endfunction

  // Expected {addr_ok, data_ok, err, req[2:0], rdata} from the transaction view.
  function automatic logic [37:0] model_out();
    logic aok, dok, err;
    logic [2:0] rq;
    logic [31:0] rd;
    int d;
    aok = 1'b0; dok = 1'b0; err = 1'b0; rq = 3'b000; rd = 32'h0;
    if (!m_busy) begin
      d = decode(cpu_addr);
      if (cpu_req) begin
        rq[d] = 1'b1;
        aok = sao[d];
      end
    end else if (m_age >= TO) begin
      dok = 1'b1; err = 1'b1; rd = ERR_DATA;
    end else if (sdo[m_owner]) begin
      dok = 1'b1; rd = srd[m_owner];
    end
    return {aok, dok, err, rq, rd};
  endfunction

  always @(posedge clk) begin
    m_now = model_out();
    if (rst) m_busy = 1'b0;
    else if (!m_busy) begin
      if (m_now[37]) begin
        m_busy = 1'b1; m_owner = decode(cpu_addr); m_age = 0;
      end
    end else if (m_now[36]) m_busy = 1'b0;
    else m_age++;
  end

  task automatic clear_inputs();
    rst = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 2'd2;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; sao = 3'b000; sdo = 3'b000;
    for (int i = 0; i < 3; i++) srd[i] = $urandom;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    sdo = 3'b111;
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (obs !== 38'h0) begin
        bad++; $display("FAIL reset cyc=%0d got=%h exp=%h", c, obs, 38'h0);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_read();
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      srd[0] = 32'h1234_5678;
      case (c)
        0: begin cpu_req = 1'b1; cpu_addr = 32'h0000_1000; end
        1: begin cpu_req = 1'b1; cpu_addr = 32'h0000_1000; sao[0] = 1'b1; end
        3: sdo[0] = 1'b1;
        4: begin cpu_req = 1'b1; cpu_addr = 32'h0000_2000; sao[0] = 1'b1; end
        5: sdo[0] = 1'b1;
        default: ;
      endcase
      @(negedge clk);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL read cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
      if (c == 3) begin
        total++;
        if ({cpu_data_ok, cpu_rdata} !== {1'b1, 32'h1234_5678}) begin
          bad++; $display("FAIL read_data got=%b/%h exp=1/12345678", cpu_data_ok, cpu_rdata);
        end
      end
      if (c == 4) begin
        total++;
        if (cpu_addr_ok !== 1'b1) begin
          bad++; $display("FAIL read_next_accept got=%b exp=1", cpu_addr_ok);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic s0_seen = 1'b0;
    logic [31:0] rv = $urandom;
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      srd[2] = rv;
      case (c)
        0: begin cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h1FAF_F020; cpu_wdata = $urandom; sao = 3'b111; end
        1: sdo[1] = 1'b1;
        2: begin cpu_req = 1'b1; cpu_addr = 32'h1FC0_0004; sao = 3'b111; end
        3: sdo[2] = 1'b1;
        default: ;
      endcase
      @(negedge clk);
      s0_seen |= s0_req;
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL b2b cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
      if (c == 3) begin
        total++;
        if (cpu_rdata !== rv) begin
          bad++; $display("FAIL b2b_rdata got=%h exp=%h", cpu_rdata, rv);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (s0_seen !== 1'b0) begin
      bad++; $display("FAIL b2b_s0_quiet got=%b exp=0", s0_seen);
    end
  endtask

  task automatic test_ignore_others();
    logic [31:0] rv = $urandom;
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      srd[0] = 32'hFFFF_FFFF; srd[2] = 32'hFFFF_FFFF; srd[1] = rv;
      case (c)
        0: begin cpu_req = 1'b1; cpu_addr = 32'h1FAF_0010; sao = 3'b111; end
        1, 2: sdo = 3'b101;
        3: sdo = 3'b010;
        default: ;
      endcase
      @(negedge clk);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL ignore cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
      if (c == 3) begin
        total++;
        if ({cpu_data_ok, cpu_rdata} !== {1'b1, rv}) begin
          bad++; $display("FAIL ignore_owner got=%b/%h exp=1/%h", cpu_data_ok, cpu_rdata, rv);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    int hit = -1;
    logic [31:0] hit_rd = 32'h0;
    logic hit_err = 1'b0;
    for (int c = 0; c < 10; c++) begin
      clear_inputs();
      if (c == 0) begin cpu_req = 1'b1; cpu_addr = 32'h0000_2000; sao[0] = 1'b1; end
      if (c >= 7) sdo[0] = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL timeout cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
      if (c > 0 && cpu_data_ok === 1'b1 && hit < 0) begin
        hit = c; hit_rd = cpu_rdata; hit_err = cpu_err;
      end
      @(posedge clk); #1;
    end
    total++;
    if (hit != 5 || hit_rd !== ERR_DATA || hit_err !== 1'b1) begin
      bad++; $display("FAIL timeout_err got=cyc%0d/%h/%b exp=cyc5/%h/1", hit, hit_rd, hit_err, ERR_DATA);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 7; c++) begin
      clear_inputs();
      case (c)
        0: begin cpu_req = 1'b1; cpu_addr = 32'h1FAF_0100; sao[1] = 1'b1; end
        2: rst = 1'b1;
        3: sdo[1] = 1'b1;
        4: begin cpu_req = 1'b1; cpu_addr = 32'h1FC1_2340; sao[2] = 1'b1; end
        5: sdo[2] = 1'b1;
        default: ;
      endcase
      @(negedge clk);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL rst_mid cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
      if (c == 3) begin
        total++;
        if (cpu_data_ok !== 1'b0) begin
          bad++; $display("FAIL rst_mid_drop got=%b exp=0", cpu_data_ok);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      if (c <= 3) begin cpu_req = 1'b1; cpu_addr = 32'h1FAF_0040; end
      if (c == 3) sao[1] = 1'b1;
      if (c == 4) sdo[1] = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL hold cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
      if (c <= 3) begin
        total++;
        if ({s1_req, cpu_addr_ok} !== {1'b1, (c == 3)}) begin
          bad++; $display("FAIL hold_hs cyc=%0d got=%b%b exp=1%b", c, s1_req, cpu_addr_ok, (c == 3));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(199) == 0);
      cpu_req = ($urandom_range(9) < 7);
      cpu_wr = $urandom;
      cpu_size = $urandom;
      cpu_wdata = $urandom;
      case ($urandom_range(2))
        0: cpu_addr = $urandom;
        1: cpu_addr = S1_BASE | ($urandom & ~S1_MASK);
        default: cpu_addr = S2_BASE | ($urandom & ~S2_MASK);
      endcase
      sao = $urandom;
      sdo = {($urandom_range(2) == 0), ($urandom_range(2) == 0), ($urandom_range(2) == 0)};
      for (int i = 0; i < 3; i++) srd[i] = $urandom;
      @(negedge clk);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL random cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
      total++;
      if ({s0_wr, s1_wr, s2_wr, s0_size, s1_size, s2_size, s0_addr, s1_addr, s2_addr, s0_wdata, s1_wdata, s2_wdata}
          !== {{3{cpu_wr}}, {3{cpu_size}}, {3{cpu_addr}}, {3{cpu_wdata}}}) begin
        bad++; $display("FAIL broadcast cyc=%0d got=%h/%h/%h exp=%h", c, s0_addr, s1_addr, s2_addr, cpu_addr);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_read();
    test_back_to_back();
    test_ignore_others();
    test_timeout();
    test_reset_mid();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
